biu_datapath: RTL

- Address/data path stage directly downstream of the BIU control block.
- Consumes StoreReg, AddrSel, EnRdata and EnWdata.
- Latches the master address, splits it into bank/row/column, and drives the SDRAM address pins for each command.
- Gates write data onto DQ, counts burst beats, and buffers read beats in a first-word-fall-through FIFO that the bus master drains.

---
 rtl/biu_pkg.sv | 44 ++++
 rtl/biu_rd_fifo.sv | 88 ++++++++
 rtl/biu_datapath.sv | 134 +++++++++++++
 3 files changed

// File: rtl/biu_pkg.sv
// Shared constants, encodings and burst-length helpers for the BIU address/data path.
package biu_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int COL_W_DEF    = 10;
    localparam int ROW_W_DEF    = 13;
    localparam int BANK_W_DEF   = 2;
    localparam int RD_DEPTH_DEF = 8;

    // SDRAM address pin source selected by the control block
    typedef enum logic [1:0] {
        ASEL_PRE  = 2'b00,
        ASEL_COL  = 2'b01,
        ASEL_ROW  = 2'b10,
        ASEL_ROW2 = 2'b11
    } asel_e;

    // Burst length codes (4..6 behave like 8 beats)
    localparam logic [2:0] TB_LEN1 = 3'd0;
    localparam logic [2:0] TB_LEN2 = 3'd1;
    localparam logic [2:0] TB_LEN4 = 3'd2;
    localparam logic [2:0] TB_LEN8 = 3'd3;
    localparam logic [2:0] TB_FULL = 3'd7;

    // Beats per burst; full page uses 8 for beat ordering purposes
    function automatic logic [3:0] burst_len(input logic [2:0] tb);
        logic [3:0] len;
        case (tb)
            TB_LEN1: len = 4'd1;
            TB_LEN2: len = 4'd2;
            TB_LEN4: len = 4'd4;
            default: len = 4'd8;
        endcase
        return len;
    endfunction

    // Low-bit mask (L-1) used for wrapping the beat offset
    function automatic logic [2:0] burst_mask(input logic [2:0] tb);
        logic [3:0] m;
        m = burst_len(tb) - 4'd1;
        return m[2:0];
    endfunction

endpackage

// File: rtl/biu_rd_fifo.sv
// First-word-fall-through read-beat FIFO with sticky overflow flag.
module biu_rd_fifo
    import biu_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = RD_DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_ovf_clr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == {CW{1'b0}});
    // A pop on empty is ignored; a push on full only lands if a pop frees a slot
    assign w_do_pop  = i_en & i_pop & ~w_empty;
    assign w_do_push = i_en & i_push & (~w_full | w_do_pop);

    // Storage write; contents need no reset because the head is masked while empty
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            else           r_wr_ptr <= r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            else           r_rd_ptr <= r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a dropped beat sets it, only reset or the clear input removes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (i_en && i_ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (i_en && i_push && w_full && !w_do_pop) begin
            r_ovf <= 1'b1;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign o_rdata = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/biu_datapath.sv
// BIU address/data path: address latch and split, SDRAM address muxing,
// write-data gating, burst beat ordering and the read-beat FIFO.
module biu_datapath
    import biu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int COL_W    = COL_W_DEF,
    parameter int ROW_W    = ROW_W_DEF,
    parameter int BANK_W   = BANK_W_DEF,
    parameter int RD_DEPTH = RD_DEPTH_DEF
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        En,
    input  logic                        StoreReg,
    input  logic [1:0]                  AddrSel,
    input  logic                        EnRdata,
    input  logic                        EnWdata,
    input  logic                        addr_mode,
    input  logic [2:0]                  tburst,
    input  logic [31:0]                 AddrIn,
    input  logic [DATA_W-1:0]           DataIn,
    input  logic [DATA_W-1:0]           SdramDqIn,
    input  logic                        RdPop,
    output logic [ROW_W-1:0]            SdramAddr,
    output logic [BANK_W-1:0]           SdramBa,
    output logic [DATA_W-1:0]           SdramDqOut,
    output logic                        SdramDqOe,
    output logic [2:0]                  BurstIdx,
    output logic                        BurstDone,
    output logic [DATA_W-1:0]           RdData,
    output logic                        RdEmpty,
    output logic [$clog2(RD_DEPTH):0]   RdCount,
    output logic                        RdOvf
);

    localparam int ADDR_USED = COL_W + ROW_W + BANK_W;
    localparam int A10_BIT   = 10;

    logic [ADDR_USED-1:0] r_addr;
    logic [2:0]           r_cnt;

    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ROW_W-1:0]  w_sdram_addr;
    logic [2:0]        w_c3;
    logic [2:0]        w_mask;
    logic              w_full_page;
    logic              w_beat;
    logic              w_last;
    logic              w_unused_addr;

    // Address bits above the bank field carry no meaning here
    assign w_unused_addr = ^AddrIn[31:ADDR_USED];

    assign w_col   = r_addr[COL_W-1:0];
    assign w_row   = r_addr[COL_W+ROW_W-1:COL_W];
    assign SdramBa = r_addr[ADDR_USED-1:COL_W+ROW_W];

    // Master address latch
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_addr <= {ADDR_USED{1'b0}};
        end else if (En && StoreReg) begin
            r_addr <= AddrIn[ADDR_USED-1:0];
        end else begin
            r_addr <= r_addr;
        end
    end

    // SDRAM A-pin source: row, column with A10 low, or precharge-all with only A10 high
    always_comb begin
        w_sdram_addr = {ROW_W{1'b0}};
        case (AddrSel)
            ASEL_ROW, ASEL_ROW2: w_sdram_addr = w_row;
            ASEL_COL:            w_sdram_addr[COL_W-1:0] = w_col;
            ASEL_PRE:            w_sdram_addr[A10_BIT] = 1'b1;
            default:             w_sdram_addr = w_row;
        endcase
    end
    assign SdramAddr = w_sdram_addr;

    // Write data only reaches the pins while a write beat is being driven
    assign SdramDqOe  = En & EnWdata;
    assign SdramDqOut = (En && EnWdata) ? DataIn : {DATA_W{1'b0}};

    assign w_beat      = En & (EnRdata | EnWdata);
    assign w_mask      = burst_mask(tburst);
    assign w_full_page = (tburst == TB_FULL);
    assign w_last      = ~w_full_page & (r_cnt == w_mask);
    assign BurstDone   = w_beat & w_last;

    // Beat counter: cleared by a new address, returns to 0 after the last beat
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= 3'd0;
        end else if (En && StoreReg) begin
            r_cnt <= 3'd0;
        end else if (w_beat) begin
            if (w_last) r_cnt <= 3'd0;
            else        r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Beat offset: wrap within the burst-aligned block starting at the column offset
    always_comb begin
        w_c3 = w_col[2:0];
        if (addr_mode) begin
            BurstIdx = (w_c3 & ~w_mask) | ((w_c3 ^ r_cnt) & w_mask);
        end else begin
            BurstIdx = (w_c3 & ~w_mask) | ((w_c3 + r_cnt) & w_mask);
        end
    end

    biu_rd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_en      (En),
        .i_push    (EnRdata),
        .i_pop     (RdPop),
        .i_ovf_clr (StoreReg),
        .i_wdata   (SdramDqIn),
        .o_rdata   (RdData),
        .o_empty   (RdEmpty),
        .o_count   (RdCount),
        .o_ovf     (RdOvf)
    );

endmodule
